// File: rtl/sweep_max_counter.sv
// Sweep step counter and peak tracker for the tracker control FSM.
// Raises CNT_L/CNT_D during a sweep and CNT_RU while servoing back to the brightest step.
module sweep_max_counter #(
  parameter int SWEEP_STEPS = 8,
  parameter int ADC_W       = 8,
  parameter int POS_W       = $clog2(SWEEP_STEPS + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             HS,
  input  logic             VS,
  input  logic             MC,
  input  logic             CNT_RST,
  input  logic             STEP_TICK,
  input  logic [ADC_W-1:0] LIGHT,
  input  logic             LIGHT_VALID,
  output logic             CNT_L,
  output logic             CNT_D,
  output logic             CNT_RU,
  output logic [ADC_W-1:0] MAX_VAL,
  output logic [POS_W-1:0] MAX_POS,
  output logic             BUSY,
  output logic [1:0]       DBG_STATE
);

  // Handshake: HS/VS/MC are level enables sampled every edge; STEP_TICK and
  // LIGHT_VALID are single-cycle qualifiers with no back-pressure (no ready).

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    HOLD   = 2'd2,
    RETURN = 2'd3
  } state_t;

  localparam logic AXIS_H = 1'b0;
  localparam logic AXIS_V = 1'b1;
  localparam logic [POS_W-1:0] LP_STEPS = POS_W'(SWEEP_STEPS);
  localparam logic [POS_W-1:0] LP_LAST  = POS_W'(SWEEP_STEPS - 1);

  state_t           r_state;
  logic             r_axis;
  logic [POS_W-1:0] r_step_cnt;
  logic [POS_W-1:0] r_ret_cnt;
  logic             r_cnt_l;
  logic             r_cnt_d;
  logic             r_cnt_ru;
  logic [ADC_W-1:0] r_max_val;
  logic [POS_W-1:0] r_max_pos;
  logic             r_busy;

  state_t           w_state_nxt;
  logic             w_axis_nxt;
  logic [POS_W-1:0] w_step_nxt;
  logic [POS_W-1:0] w_ret_nxt;
  logic             w_cnt_l_nxt;
  logic             w_cnt_d_nxt;
  logic             w_cnt_ru_nxt;
  logic [ADC_W-1:0] w_max_val_nxt;
  logic [POS_W-1:0] w_max_pos_nxt;
  logic [ADC_W-1:0] w_peak_val;
  logic [POS_W-1:0] w_peak_pos;
  logic [POS_W-1:0] w_ret_calc;
  logic             w_axis_en;
  logic             w_start;

  // Strict compare keeps the earliest position on ties; a zero reading never wins.
  always_comb begin
    w_peak_val = r_max_val;
    w_peak_pos = r_max_pos;
    if ((r_state == SWEEP || r_state == HOLD) && LIGHT_VALID && (LIGHT > r_max_val)) begin
      w_peak_val = LIGHT;
      w_peak_pos = r_step_cnt;
    end
  end

  assign w_ret_calc = LP_STEPS - w_peak_pos;
  assign w_axis_en  = (r_axis == AXIS_V) ? VS : HS;

  always_comb begin
    w_state_nxt   = r_state;
    w_axis_nxt    = r_axis;
    w_step_nxt    = r_step_cnt;
    w_ret_nxt     = r_ret_cnt;
    w_cnt_l_nxt   = r_cnt_l;
    w_cnt_d_nxt   = r_cnt_d;
    w_cnt_ru_nxt  = r_cnt_ru;
    w_max_val_nxt = w_peak_val;
    w_max_pos_nxt = w_peak_pos;
    w_start       = 1'b0;

    case (r_state)
      IDLE: begin
        w_start = HS | VS;
      end
      SWEEP: begin
        if (!w_axis_en) begin
          w_state_nxt = IDLE;
          w_cnt_l_nxt = 1'b0;
          w_cnt_d_nxt = 1'b0;
        end else if (STEP_TICK && (r_step_cnt != LP_STEPS)) begin
          w_step_nxt = r_step_cnt + 1'b1;
          if (r_step_cnt == LP_LAST) begin
            w_state_nxt = HOLD;
            w_cnt_l_nxt = 1'b0;
            w_cnt_d_nxt = 1'b0;
          end
        end
      end
      HOLD: begin
        if (MC) begin
          w_ret_nxt = w_ret_calc;
          if (w_ret_calc != '0) begin
            w_state_nxt  = RETURN;
            w_cnt_ru_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if ((r_axis == AXIS_H) ? VS : HS) begin
          w_start = 1'b1;
        end
      end
      RETURN: begin
        if (!MC) begin
          w_state_nxt  = IDLE;
          w_cnt_ru_nxt = 1'b0;
        end else if (STEP_TICK && (r_ret_cnt != '0)) begin
          w_ret_nxt = r_ret_cnt - 1'b1;
          if (r_ret_cnt == POS_W'(1)) begin
            w_state_nxt  = IDLE;
            w_cnt_ru_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // HS wins when both enables are high.
    if (w_start) begin
      w_state_nxt   = SWEEP;
      w_axis_nxt    = HS ? AXIS_H : AXIS_V;
      w_step_nxt    = '0;
      w_max_val_nxt = '0;
      w_max_pos_nxt = '0;
      w_cnt_l_nxt   = HS;
      w_cnt_d_nxt   = ~HS;
      w_cnt_ru_nxt  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_axis     <= AXIS_H;
      r_step_cnt <= '0;
      r_ret_cnt  <= '0;
      r_cnt_l    <= 1'b0;
      r_cnt_d    <= 1'b0;
      r_cnt_ru   <= 1'b0;
      r_max_val  <= '0;
      r_max_pos  <= '0;
      r_busy     <= 1'b0;
    end else if (CNT_RST) begin
      r_state    <= IDLE;
      r_axis     <= AXIS_H;
      r_step_cnt <= '0;
      r_ret_cnt  <= '0;
      r_cnt_l    <= 1'b0;
      r_cnt_d    <= 1'b0;
      r_cnt_ru   <= 1'b0;
      r_max_val  <= '0;
      r_max_pos  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_axis     <= w_axis_nxt;
      r_step_cnt <= w_step_nxt;
      r_ret_cnt  <= w_ret_nxt;
      r_cnt_l    <= w_cnt_l_nxt;
      r_cnt_d    <= w_cnt_d_nxt;
      r_cnt_ru   <= w_cnt_ru_nxt;
      r_max_val  <= w_max_val_nxt;
      r_max_pos  <= w_max_pos_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  assign CNT_L     = r_cnt_l;
  assign CNT_D     = r_cnt_d;
  assign CNT_RU    = r_cnt_ru;
  assign MAX_VAL   = r_max_val;
  assign MAX_POS   = r_max_pos;
  assign BUSY      = r_busy;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_sweep_max_counter.sv
// Directed bench for sweep_max_counter with hand-computed expectations.
module tb_sweep_max_counter;

  logic       CLK;
  logic       RST_N;
  logic       HS, VS, MC, CNT_RST, STEP_TICK, LIGHT_VALID;
  logic [7:0] LIGHT;
  logic       CNT_L, CNT_D, CNT_RU, BUSY;
  logic [7:0] MAX_VAL;
  logic [3:0] MAX_POS;
  logic [1:0] DBG_STATE;

  int n_checks = 0;
  int n_errors = 0;

  sweep_max_counter #(.SWEEP_STEPS(8), .ADC_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .HS(HS), .VS(VS), .MC(MC), .CNT_RST(CNT_RST),
    .STEP_TICK(STEP_TICK), .LIGHT(LIGHT), .LIGHT_VALID(LIGHT_VALID),
    .CNT_L(CNT_L), .CNT_D(CNT_D), .CNT_RU(CNT_RU), .MAX_VAL(MAX_VAL),
    .MAX_POS(MAX_POS), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // driver: apply inputs for one edge, then sample 1 ns after it
  task automatic drive(input logic hs, input logic vs, input logic mc,
                       input logic tk, input logic lv, input logic [7:0] lt);
    HS = hs; VS = vs; MC = mc; STEP_TICK = tk; LIGHT_VALID = lv; LIGHT = lt;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_cnt_l"}, CNT_L, 0);
    check({tag, "_cnt_d"}, CNT_D, 0);
    check({tag, "_cnt_ru"}, CNT_RU, 0);
    check({tag, "_max_val"}, MAX_VAL, 0);
    check({tag, "_max_pos"}, MAX_POS, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_state"}, DBG_STATE, 0);
  endtask

  logic [7:0] t2_light [8] = '{8'd10, 8'd40, 8'd90, 8'd90, 8'd30, 8'd0, 8'd0, 8'd0};

  initial begin
    RST_N = 1'b0; CNT_RST = 1'b0;
    HS = 0; VS = 0; MC = 0; STEP_TICK = 0; LIGHT_VALID = 0; LIGHT = '0;
    #12;
    check_idle_zero("reset");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    drive(0, 0, 1, 1, 0, 0);
    check("idle_mc_ignored", DBG_STATE, 0);

    // H sweep, peak 90 at step 2 (tie at 3 ignored), then 6-tick return
    drive(1, 0, 0, 0, 0, 0);
    check("t2_cnt_l_start", CNT_L, 1);
    check("t2_cnt_d_start", CNT_D, 0);
    check("t2_busy", BUSY, 1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 1, (i < 5), t2_light[i]);
      check($sformatf("t2_cnt_l_tick%0d", i), CNT_L, (i < 7) ? 1 : 0);
    end
    check("t2_state_hold", DBG_STATE, 2);
    check("t2_max_val", MAX_VAL, 90);
    check("t2_max_pos", MAX_POS, 2);
    drive(0, 0, 1, 0, 0, 0);
    check("t2_ru_start", CNT_RU, 1);
    check("t2_state_ret", DBG_STATE, 3);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        drive(0, 0, 1, 0, 0, 0);
        check("t2_ru_no_tick", CNT_RU, 1);
      end
      drive(0, 0, 1, 1, 0, 0);
      check($sformatf("t2_ru_tick%0d", i), CNT_RU, (i < 5) ? 1 : 0);
    end
    check("t2_end_state", DBG_STATE, 0);
    check("t2_end_busy", BUSY, 0);

    // async reset in the middle of RETURN
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 1, (i == 0), 8'd50);
    check("t1_max_pos", MAX_POS, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    check("t1_ru_before_rst", CNT_RU, 1);
    HS = 0; VS = 0; MC = 0; STEP_TICK = 0; LIGHT_VALID = 0;
    RST_N = 1'b0;
    #2;
    check_idle_zero("t1_async");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    check("t1_cnt_l_after_rst", CNT_L, 1);

    // HS dropped at step_cnt=4: abort with MAX_* retained
    drive(1, 0, 0, 1, 1, 8'd70);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("t5_abort_cnt_l", CNT_L, 0);
    check("t5_abort_busy", BUSY, 0);
    check("t5_abort_max_val", MAX_VAL, 70);
    check("t5_abort_max_pos", MAX_POS, 0);

    // HS and VS together, coincident tick + peak at step 3, CNT_RST at step 5
    drive(1, 1, 0, 0, 0, 0);
    check("t4_cnt_l", CNT_L, 1);
    check("t4_cnt_d", CNT_D, 0);
    check("t4_max_cleared", MAX_VAL, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 0, 0);
    drive(1, 1, 0, 1, 1, 8'd77);
    check("t4_max_val", MAX_VAL, 77);
    check("t4_max_pos", MAX_POS, 3);
    drive(1, 1, 0, 1, 0, 0);
    CNT_RST = 1'b1;
    drive(1, 0, 0, 1, 1, 8'd99);
    CNT_RST = 1'b0;
    check_idle_zero("t4_cnt_rst");

    // V sweep, peak read in HOLD at step 8 -> no return
    drive(0, 1, 0, 0, 0, 0);
    check("t3_cnt_d", CNT_D, 1);
    check("t3_cnt_l", CNT_L, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 1, (i == 1), 8'd20);
    check("t3_cnt_d_done", CNT_D, 0);
    check("t3_max_pos_sweep", MAX_POS, 1);
    drive(0, 0, 0, 0, 1, 8'd200);
    check("t3_max_val", MAX_VAL, 200);
    check("t3_max_pos", MAX_POS, 8);
    check("t3_hold", DBG_STATE, 2);
    drive(0, 0, 1, 0, 0, 0);
    check("t3_ru_never", CNT_RU, 0);
    check("t3_idle", DBG_STATE, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("t3_ru_never2", CNT_RU, 0);

    // H sweep clears MAX, return of 3, VS in the cycle CNT_RU falls
    drive(1, 0, 0, 0, 0, 0);
    check("t6_max_val_clr", MAX_VAL, 0);
    check("t6_max_pos_clr", MAX_POS, 0);
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 1, (i == 5), 8'd120);
    check("t6_max_pos", MAX_POS, 5);
    drive(0, 0, 1, 0, 0, 0);
    check("t6_ru_start", CNT_RU, 1);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    check("t6_ru_mid", CNT_RU, 1);
    drive(0, 0, 1, 1, 0, 0);
    check("t6_ru_fall", CNT_RU, 0);
    check("t6_cnt_d_not_yet", CNT_D, 0);
    drive(0, 1, 0, 0, 0, 0);
    check("t6_cnt_d", CNT_D, 1);
    check("t6_cnt_l", CNT_L, 0);
    check("t6_ru_low", CNT_RU, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("t6_vs_abort", CNT_D, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
